shift_engine: RTL and testbench

Parametrised serial/parallel shift engine for the UART datapath. It is the successor to the fixed 8-bit shifter and replaces it on both the TX path (parallel load, serial out) and the RX path (serial in, parallel out). It adds generic width, an explicit bit counter, frame busy/done handshake, rotate mode, and a direction latched at load. The vacated end always receives the serial input in shift mode.

---
 rtl/shift_engine.sv | 98 +++++++++
 tb/tb_shift_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_engine.sv
// rtl/shift_engine.sv - parametrised serial/parallel shift engine for the UART datapath
// Parallel load starts a frame of WIDTH en-qualified shifts; direction and rotate mode are latched at load.
module shift_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic             dir_sel,
    input  logic             rot,
    input  logic             sin,
    input  logic [WIDTH-1:0] in_parallel,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic             done_q, done_d;
    logic             left_in, right_in;

    // Bit entering the vacated end: the outgoing bit in rotate mode, sin otherwise.
    assign left_in  = rot_q ? buf_q[WIDTH-1] : sin;
    assign right_in = rot_q ? buf_q[0]       : sin;

    generate
        if (WIDTH == 1) begin : g_w1
            assign shifted = left_in;
        end else begin : g_wn
            assign shifted = dir_q ? {buf_q[WIDTH-2:0], left_in}
                                   : {right_in, buf_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        done_d  = 1'b0;
        if (ld) begin
            // Load wins over shifting and silently aborts any frame in flight.
            state_d = SHIFT;
            buf_d   = in_parallel;
            cnt_d   = '0;
            dir_d   = dir_sel;
            rot_d   = rot;
        end else if (state_q == SHIFT && en) begin
            buf_d = shifted;
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign out  = buf_q;
    assign sout = dir_q ? buf_q[WIDTH-1] : buf_q[0];
    assign busy = (state_q == SHIFT);
    assign done = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// tb/tb_shift_engine.sv - scoreboard bench for shift_engine at WIDTH 8, 1 and 16
// All three instances share control inputs; a behavioural model predicts each edge.
module tb_shift_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, ld = 1'b0, dir_sel = 1'b0, rot = 1'b0, sin = 1'b0;
    logic [7:0]  in8 = '0;
    logic [0:0]  in1 = '0;
    logic [15:0] in16 = '0;
    logic [7:0]  out8;
    logic [0:0]  out1;
    logic [15:0] out16;
    logic        sout8, sout1, sout16;
    logic        busy8, busy1, busy16;
    logic        done8, done1, done16;

    always #5 clk = ~clk;

    shift_engine #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .dir_sel(dir_sel), .rot(rot), .sin(sin),
        .in_parallel(in8), .out(out8), .sout(sout8), .busy(busy8), .done(done8)
    );
    shift_engine #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .dir_sel(dir_sel), .rot(rot), .sin(sin),
        .in_parallel(in1), .out(out1), .sout(sout1), .busy(busy1), .done(done1)
    );
    shift_engine #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .dir_sel(dir_sel), .rot(rot), .sin(sin),
        .in_parallel(in16), .out(out16), .sout(sout16), .busy(busy16), .done(done16)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          inst;
        logic [31:0] out;
        logic        sout;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          mw[3] = '{8, 1, 16};
    logic [31:0] mbuf[3];
    int          mcnt[3];
    logic        mdir[3], mrot[3], mbusy[3], mdone[3];
    int          busy_cnt[3], done_cnt[3];

    function automatic logic [31:0] pin(input int i);
        case (i)
            0:       return {24'h0, in8};
            1:       return {31'h0, in1};
            default: return {16'h0, in16};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mbuf[i] = '0; mcnt[i] = 0; mdir[i] = 0; mrot[i] = 0; mbusy[i] = 0; mdone[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int          w;
        logic [31:0] mask;
        logic        ob, ib;
        w    = mw[i];
        mask = (32'h1 << w) - 1;
        mdone[i] = 1'b0;
        if (ld) begin
            mbuf[i] = pin(i); mdir[i] = dir_sel; mrot[i] = rot; mcnt[i] = 0; mbusy[i] = 1'b1;
        end else if (mbusy[i] && en) begin
            ob = mdir[i] ? mbuf[i][w-1] : mbuf[i][0];
            ib = mrot[i] ? ob : sin;
            if (mdir[i]) mbuf[i] = ((mbuf[i] << 1) & mask) | {31'h0, ib};
            else         mbuf[i] = (mbuf[i] >> 1) | ({31'h0, ib} << (w - 1));
            mcnt[i]++;
            if (mcnt[i] == w) begin
                mcnt[i] = 0; mbusy[i] = 1'b0; mdone[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        exp_t e, a;
        for (int i = 0; i < 3; i++) begin
            if (!rst) model_reset();
            else model_step(i);
            e.inst = i;
            e.out  = mbuf[i];
            e.sout = mdir[i] ? mbuf[i][mw[i]-1] : mbuf[i][0];
            e.busy = mbusy[i];
            e.done = mdone[i];
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.inst)
                0:       begin a.out = {24'h0, out8};  a.sout = sout8;  a.busy = busy8;  a.done = done8;  end
                1:       begin a.out = {31'h0, out1};  a.sout = sout1;  a.busy = busy1;  a.done = done1;  end
                default: begin a.out = {16'h0, out16}; a.sout = sout16; a.busy = busy16; a.done = done16; end
            endcase
            check($sformatf("w%0d_out", mw[e.inst]),  a.out,  e.out);
            check($sformatf("w%0d_sout", mw[e.inst]), {31'h0, a.sout}, {31'h0, e.sout});
            check($sformatf("w%0d_busy", mw[e.inst]), {31'h0, a.busy}, {31'h0, e.busy});
            check($sformatf("w%0d_done", mw[e.inst]), {31'h0, a.done}, {31'h0, e.done});
            if (a.busy) busy_cnt[e.inst]++;
            if (a.done) done_cnt[e.inst]++;
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] = 0; done_cnt[i] = 0;
        end
    endtask

    logic [7:0] pat;
    logic [7:0] s3_exp[8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

    initial begin
        model_reset();
        clr_counts();
        @(negedge clk);
        @(negedge clk);
        check("rst_out", {24'h0, out8}, 32'h0);
        check("rst_sout", {31'h0, sout8}, 32'h0);
        check("rst_busy", {31'h0, busy8}, 32'h0);
        check("rst_done", {31'h0, done8}, 32'h0);
        rst = 1'b1;

        // Scenario 1: right shift 0xA5 with sin=1, en tied high, all widths.
        clr_counts();
        in8 = 8'hA5; in1 = 1'b1; in16 = 16'h00A5;
        dir_sel = 0; rot = 0; sin = 1; en = 1; ld = 1;
        tick();
        ld = 0;
        pat = 8'hA5;
        for (int k = 0; k < 16; k++) begin
            if (k < 8) check($sformatf("s1_sout%0d", k), {31'h0, sout8}, {31'h0, pat[k]});
            tick();
        end
        check("s1_out8", {24'h0, out8}, 32'hFF);
        check("s1_busy8", busy_cnt[0], 8);
        check("s1_done8", done_cnt[0], 1);
        check("s1_out1", {31'h0, out1}, 32'h1);
        check("s1_busy1", busy_cnt[1], 1);
        check("s1_done1", done_cnt[1], 1);
        check("s1_out16", {16'h0, out16}, 32'hFFFF);
        check("s1_busy16", busy_cnt[2], 16);
        check("s1_done16", done_cnt[2], 1);

        // Scenario 2: left shift 0x3C, sin=0, en one cycle in three.
        clr_counts();
        in8 = 8'h3C; dir_sel = 1; rot = 0; sin = 0; en = 0; ld = 1;
        tick();
        ld = 0;
        for (int p = 0; p < 8; p++) begin
            en = 0; tick(); tick();
            en = 1; tick();
            if (p == 0) check("s2_first", {24'h0, out8}, 32'h78);
            if (p == 1) check("s2_second", {24'h0, out8}, 32'hF0);
        end
        check("s2_out", {24'h0, out8}, 32'h00);
        check("s2_done_now", {31'h0, done8}, 32'h1);
        en = 0; tick();
        check("s2_done_after", {31'h0, done8}, 32'h0);
        check("s2_done_cnt", done_cnt[0], 1);

        // Scenario 3: left rotate 0x81; sin and dir_sel wiggle mid-frame.
        in8 = 8'h81; dir_sel = 1; rot = 1; ld = 1; en = 1;
        tick();
        ld = 0;
        for (int k = 0; k < 8; k++) begin
            sin = k[0];
            dir_sel = ~dir_sel;
            tick();
            check($sformatf("s3_out%0d", k), {24'h0, out8}, {24'h0, s3_exp[k]});
        end

        // Scenario 4: RX path, receive 0x5A LSB first then hold through idle strobes.
        clr_counts();
        in8 = 8'h00; dir_sel = 0; rot = 0; ld = 1;
        tick();
        ld = 0;
        pat = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            sin = pat[k];
            tick();
        end
        check("s4_out", {24'h0, out8}, 32'h5A);
        check("s4_done", {31'h0, done8}, 32'h1);
        for (int k = 0; k < 10; k++) begin
            sin = 1'($urandom_range(0, 1));
            tick();
        end
        check("s4_hold", {24'h0, out8}, 32'h5A);
        check("s4_done_cnt", done_cnt[0], 1);

        // Scenario 5: abort after 3 shifts, then reload in the done cycle.
        clr_counts();
        in8 = 8'hFF; sin = 0; ld = 1;
        tick();
        ld = 0;
        tick(); tick(); tick();
        in8 = 8'h0F; ld = 1;
        tick();
        ld = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 7) check($sformatf("s5_nodone%0d", k), {31'h0, done8}, 32'h0);
        end
        check("s5_done", {31'h0, done8}, 32'h1);
        check("s5_done_cnt", done_cnt[0], 1);
        in8 = 8'hC3; ld = 1;
        tick();
        ld = 0;
        check("s5_reld_done", {31'h0, done8}, 32'h0);
        check("s5_reld_busy", {31'h0, busy8}, 32'h1);

        // Scenario 6: asynchronous reset mid-frame, then strobes without a load.
        for (int k = 0; k < 5; k++) tick();
        #2;
        rst = 1'b0;
        #1;
        check("s6_out", {24'h0, out8}, 32'h0);
        check("s6_busy", {31'h0, busy8}, 32'h0);
        check("s6_done", {31'h0, done8}, 32'h0);
        check("s6_sout", {31'h0, sout8}, 32'h0);
        check("s6_out16", {16'h0, out16}, 32'h0);
        model_reset();
        @(negedge clk);
        tick();
        rst = 1'b1;
        clr_counts();
        for (int k = 0; k < 5; k++) begin
            sin = 1;
            tick();
        end
        check("s6_idle_out", {24'h0, out8}, 32'h0);
        check("s6_idle_busy", busy_cnt[0], 0);
        check("s6_idle_done", done_cnt[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
